// File: rtl/psum_mem_arbiter.sv
// Arbiter for the partial-sum accumulator memory: the loop controller always wins each port and
// the host fills idle slots. An owner pipeline routes read data back to whoever issued the read.
module psum_mem_arbiter #(
    parameter int LOG2_OF_MEM_HEIGHT = 20,
    parameter int DATA_WIDTH         = 32,
    parameter int READ_LATENCY       = 1,
    parameter int STARVE_LIMIT       = 8
) (
    input  logic                          clk,
    input  logic                          arst_in,
    input  logic                          running,
    input  logic                          ctrl_we,
    input  logic [LOG2_OF_MEM_HEIGHT-1:0] ctrl_write_addr,
    input  logic [DATA_WIDTH-1:0]         ctrl_wdata,
    input  logic                          ctrl_re,
    input  logic [LOG2_OF_MEM_HEIGHT-1:0] ctrl_read_addr,
    output logic [DATA_WIDTH-1:0]         ctrl_rdata,
    output logic                          ctrl_rvalid,
    input  logic                          host_req,
    input  logic                          host_we,
    input  logic [LOG2_OF_MEM_HEIGHT-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0]         host_wdata,
    output logic                          host_gnt,
    output logic [DATA_WIDTH-1:0]         host_rdata,
    output logic                          host_rvalid,
    output logic                          host_starved,
    input  logic                          host_starved_clr,
    output logic                          mem_we,
    output logic [LOG2_OF_MEM_HEIGHT-1:0] mem_write_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    output logic                          mem_re,
    output logic [LOG2_OF_MEM_HEIGHT-1:0] mem_read_addr,
    input  logic [DATA_WIDTH-1:0]         mem_rdata
);

    localparam logic [16:0] STARVE_THRESH = 17'(STARVE_LIMIT);

    logic                    host_wr_gnt;
    logic                    host_rd_gnt;
    logic                    host_waiting;
    logic                    starve_hit;
    logic [15:0]             wait_cnt;
    logic [READ_LATENCY-1:0] pipe_valid;
    logic [READ_LATENCY-1:0] pipe_host;

    // Write port: the controller owns it whenever it writes; host writes are locked out while running.
    always_comb begin
        mem_we         = 1'b0;
        mem_write_addr = '0;
        mem_wdata      = '0;
        host_wr_gnt    = 1'b0;
        if (ctrl_we) begin
            mem_we         = 1'b1;
            mem_write_addr = ctrl_write_addr;
            mem_wdata      = ctrl_wdata;
        end else if (host_req && host_we && !running) begin
            mem_we         = 1'b1;
            mem_write_addr = host_addr;
            mem_wdata      = host_wdata;
            host_wr_gnt    = 1'b1;
        end
    end

    always_comb begin
        mem_re        = 1'b0;
        mem_read_addr = '0;
        host_rd_gnt   = 1'b0;
        if (ctrl_re) begin
            mem_re        = 1'b1;
            mem_read_addr = ctrl_read_addr;
        end else if (host_req && !host_we) begin
            mem_re        = 1'b1;
            mem_read_addr = host_addr;
            host_rd_gnt   = 1'b1;
        end
    end

    assign host_gnt = host_wr_gnt | host_rd_gnt;

    // Owner pipeline tracks who issued each read, one stage per memory latency cycle.
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            pipe_valid <= '0;
            pipe_host  <= '0;
        end else begin
            pipe_valid[0] <= mem_re;
            pipe_host[0]  <= host_rd_gnt;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_host[i]  <= pipe_host[i-1];
            end
        end
    end

    assign ctrl_rvalid = pipe_valid[READ_LATENCY-1] & ~pipe_host[READ_LATENCY-1];
    assign host_rvalid = pipe_valid[READ_LATENCY-1] &  pipe_host[READ_LATENCY-1];
    assign ctrl_rdata  = mem_rdata;
    assign host_rdata  = mem_rdata;

    // The wait count includes the current ungranted cycle, so the flag is visible
    // STARVE_LIMIT cycles after the first one the host had to wait.
    assign host_waiting = host_req && !host_gnt;
    assign starve_hit   = host_waiting && (({1'b0, wait_cnt} + 17'd1) >= STARVE_THRESH);

    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            wait_cnt <= '0;
        end else if (!host_waiting) begin
            wait_cnt <= '0;
        end else if (wait_cnt != 16'hFFFF) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            host_starved <= 1'b0;
        end else if (starve_hit) begin
            host_starved <= 1'b1;
        end else if (host_starved_clr) begin
            host_starved <= 1'b0;
        end
    end

endmodule

// File: tb/tb_psum_mem_arbiter.sv
// Directed bench for psum_mem_arbiter: one instance with READ_LATENCY=1 and one with
// READ_LATENCY=3, each backed by a small behavioral memory macro (old data on read-during-write).
module tb_psum_mem_arbiter;

    logic        clk;
    logic        arst_in;
    logic        mem_init;
    logic        running;
    logic        ctrl_we;
    logic [19:0] ctrl_write_addr;
    logic [31:0] ctrl_wdata;
    logic        ctrl_re;
    logic [19:0] ctrl_read_addr;
    logic        host_req;
    logic        host_we;
    logic [19:0] host_addr;
    logic [31:0] host_wdata;
    logic        host_starved_clr;

    logic [31:0] d1_ctrl_rdata, d1_host_rdata, d1_mem_wdata, d1_mem_rdata;
    logic        d1_ctrl_rvalid, d1_host_gnt, d1_host_rvalid, d1_host_starved, d1_mem_we, d1_mem_re;
    logic [19:0] d1_mem_write_addr, d1_mem_read_addr;

    logic [31:0] d3_ctrl_rdata, d3_host_rdata, d3_mem_wdata, d3_mem_rdata;
    logic        d3_ctrl_rvalid, d3_host_gnt, d3_host_rvalid, d3_host_starved, d3_mem_we, d3_mem_re;
    logic [19:0] d3_mem_write_addr, d3_mem_read_addr;

    int tests = 0;
    int fails = 0;

    psum_mem_arbiter #(.LOG2_OF_MEM_HEIGHT(20), .DATA_WIDTH(32), .READ_LATENCY(1), .STARVE_LIMIT(8)) dut1 (
        .clk(clk), .arst_in(arst_in), .running(running),
        .ctrl_we(ctrl_we), .ctrl_write_addr(ctrl_write_addr), .ctrl_wdata(ctrl_wdata),
        .ctrl_re(ctrl_re), .ctrl_read_addr(ctrl_read_addr),
        .ctrl_rdata(d1_ctrl_rdata), .ctrl_rvalid(d1_ctrl_rvalid),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(d1_host_gnt), .host_rdata(d1_host_rdata), .host_rvalid(d1_host_rvalid),
        .host_starved(d1_host_starved), .host_starved_clr(host_starved_clr),
        .mem_we(d1_mem_we), .mem_write_addr(d1_mem_write_addr), .mem_wdata(d1_mem_wdata),
        .mem_re(d1_mem_re), .mem_read_addr(d1_mem_read_addr), .mem_rdata(d1_mem_rdata)
    );

    psum_mem_arbiter #(.LOG2_OF_MEM_HEIGHT(20), .DATA_WIDTH(32), .READ_LATENCY(3), .STARVE_LIMIT(8)) dut3 (
        .clk(clk), .arst_in(arst_in), .running(running),
        .ctrl_we(ctrl_we), .ctrl_write_addr(ctrl_write_addr), .ctrl_wdata(ctrl_wdata),
        .ctrl_re(ctrl_re), .ctrl_read_addr(ctrl_read_addr),
        .ctrl_rdata(d3_ctrl_rdata), .ctrl_rvalid(d3_ctrl_rvalid),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(d3_host_gnt), .host_rdata(d3_host_rdata), .host_rvalid(d3_host_rvalid),
        .host_starved(d3_host_starved), .host_starved_clr(host_starved_clr),
        .mem_we(d3_mem_we), .mem_write_addr(d3_mem_write_addr), .mem_wdata(d3_mem_wdata),
        .mem_re(d3_mem_re), .mem_read_addr(d3_mem_read_addr), .mem_rdata(d3_mem_rdata)
    );

    // Memory macros: word i preloads to 0x1000+i; reads see the pre-write contents.
    logic [31:0] mem1 [16];
    logic [31:0] mem3 [16];
    logic [31:0] rd1;
    logic [31:0] rd3_s0, rd3_s1, rd3_s2;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem1[i] <= 32'(32'h1000 + i);
        end else begin
            if (d1_mem_re) rd1 <= mem1[d1_mem_read_addr[3:0]];
            if (d1_mem_we) mem1[d1_mem_write_addr[3:0]] <= d1_mem_wdata;
        end
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem3[i] <= 32'(32'h1000 + i);
        end else begin
            rd3_s0 <= d3_mem_re ? mem3[d3_mem_read_addr[3:0]] : 32'h0;
            rd3_s1 <= rd3_s0;
            rd3_s2 <= rd3_s1;
            if (d3_mem_we) mem3[d3_mem_write_addr[3:0]] <= d3_mem_wdata;
        end
    end

    assign d1_mem_rdata = rd1;
    assign d3_mem_rdata = rd3_s2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle, drive the new inputs just after the edge, then let them settle.
    task automatic applyStimulus(input logic c_we, input logic [19:0] c_wa, input logic [31:0] c_wd,
                                 input logic c_re, input logic [19:0] c_ra,
                                 input logic h_req, input logic h_we, input logic [19:0] h_addr,
                                 input logic [31:0] h_wd, input logic run, input logic s_clr);
        @(posedge clk);
        #1;
        ctrl_we = c_we; ctrl_write_addr = c_wa; ctrl_wdata = c_wd;
        ctrl_re = c_re; ctrl_read_addr = c_ra;
        host_req = h_req; host_we = h_we; host_addr = h_addr; host_wdata = h_wd;
        running = run; host_starved_clr = s_clr;
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 20'd0, 32'h0, 1'b0, 20'd0, 1'b0, 1'b0, 20'd0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        arst_in = 1'b1; mem_init = 1'b1;
        running = 1'b0; ctrl_we = 1'b0; ctrl_write_addr = '0; ctrl_wdata = '0;
        ctrl_re = 1'b0; ctrl_read_addr = '0; host_req = 1'b0; host_we = 1'b0;
        host_addr = '0; host_wdata = '0; host_starved_clr = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checkOutput("rst_ctrl_rvalid", 64'(d1_ctrl_rvalid), 64'd0);
        checkOutput("rst_host_rvalid", 64'(d1_host_rvalid), 64'd0);
        checkOutput("rst_host_starved", 64'(d1_host_starved), 64'd0);
        host_req = 1'b1; host_addr = 20'd1;
        #1;
        checkOutput("rst_host_gnt_comb", 64'(d1_host_gnt), 64'd1);
        checkOutput("rst_mem_read_addr", 64'(d1_mem_read_addr), 64'd1);
        host_req = 1'b0;
        @(posedge clk);
        #1;
        arst_in = 1'b0; mem_init = 1'b0;

        // Controller read and write of the same word in one cycle
        applyStimulus(1'b1, 20'd5, 32'h11, 1'b1, 20'd5, 1'b0, 1'b0, 20'd0, 32'h0, 1'b0, 1'b0);
        checkOutput("c_mem_we", 64'(d1_mem_we), 64'd1);
        checkOutput("c_mem_re", 64'(d1_mem_re), 64'd1);
        checkOutput("c_mem_wdata", 64'(d1_mem_wdata), 64'h11);
        checkOutput("c_host_gnt", 64'(d1_host_gnt), 64'd0);
        checkOutput("c_rvalid_not_early", 64'(d1_ctrl_rvalid), 64'd0);
        applyStimulus(1'b0, 20'd0, 32'h0, 1'b1, 20'd5, 1'b0, 1'b0, 20'd0, 32'h0, 1'b0, 1'b0);
        checkOutput("c_ctrl_rvalid1", 64'(d1_ctrl_rvalid), 64'd1);
        checkOutput("c_ctrl_rdata_old", 64'(d1_ctrl_rdata), 64'h1005);
        checkOutput("c_host_rvalid", 64'(d1_host_rvalid), 64'd0);
        idleCycle();
        checkOutput("c_ctrl_rvalid2", 64'(d1_ctrl_rvalid), 64'd1);
        checkOutput("c_ctrl_rdata_new", 64'(d1_ctrl_rdata), 64'h11);
        idleCycle();
        checkOutput("c_ctrl_rvalid_off", 64'(d1_ctrl_rvalid), 64'd0);

        // Host read alongside a controller write
        applyStimulus(1'b1, 20'd9, 32'h99, 1'b0, 20'd0, 1'b1, 1'b0, 20'd3, 32'h0, 1'b0, 1'b0);
        checkOutput("hr_host_gnt", 64'(d1_host_gnt), 64'd1);
        checkOutput("hr_mem_read_addr", 64'(d1_mem_read_addr), 64'd3);
        checkOutput("hr_mem_write_addr", 64'(d1_mem_write_addr), 64'd9);
        applyStimulus(1'b0, 20'd0, 32'h0, 1'b1, 20'd9, 1'b0, 1'b0, 20'd0, 32'h0, 1'b0, 1'b0);
        checkOutput("hr_host_rvalid", 64'(d1_host_rvalid), 64'd1);
        checkOutput("hr_host_rdata", 64'(d1_host_rdata), 64'h1003);
        checkOutput("hr_ctrl_rvalid", 64'(d1_ctrl_rvalid), 64'd0);
        idleCycle();
        checkOutput("hr_ctrl_write_landed", 64'(d1_ctrl_rdata), 64'h99);
        checkOutput("hr_host_rvalid_off", 64'(d1_host_rvalid), 64'd0);

        // Collision: controller holds the read port for 10 cycles
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 20'd0, 32'h0, 1'b1, 20'd0, 1'b1, 1'b0, 20'd4, 32'h0, 1'b0, 1'b0);
            checkOutput($sformatf("col_gnt_%0d", k), 64'(d1_host_gnt), 64'd0);
            checkOutput($sformatf("col_starved_%0d", k), 64'(d1_host_starved), (k >= 8) ? 64'd1 : 64'd0);
        end
        applyStimulus(1'b0, 20'd0, 32'h0, 1'b0, 20'd0, 1'b1, 1'b0, 20'd4, 32'h0, 1'b0, 1'b0);
        checkOutput("col_gnt_release", 64'(d1_host_gnt), 64'd1);
        checkOutput("col_mem_read_addr", 64'(d1_mem_read_addr), 64'd4);
        checkOutput("col_starved_sticky", 64'(d1_host_starved), 64'd1);
        applyStimulus(1'b0, 20'd0, 32'h0, 1'b0, 20'd0, 1'b0, 1'b0, 20'd0, 32'h0, 1'b0, 1'b1);
        checkOutput("col_host_rvalid", 64'(d1_host_rvalid), 64'd1);
        checkOutput("col_host_rdata", 64'(d1_host_rdata), 64'h1004);
        checkOutput("col_starved_before_clr", 64'(d1_host_starved), 64'd1);
        idleCycle();
        checkOutput("col_starved_cleared", 64'(d1_host_starved), 64'd0);

        // Write lock while running
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 20'd0, 32'h0, 1'b0, 20'd0, 1'b1, 1'b1, 20'd7, 32'hAB, 1'b1, 1'b0);
            checkOutput($sformatf("wl_gnt_%0d", k), 64'(d1_host_gnt), 64'd0);
            checkOutput($sformatf("wl_mem_we_%0d", k), 64'(d1_mem_we), 64'd0);
        end
        applyStimulus(1'b0, 20'd0, 32'h0, 1'b0, 20'd0, 1'b1, 1'b1, 20'd7, 32'hAB, 1'b0, 1'b0);
        checkOutput("wl_gnt_release", 64'(d1_host_gnt), 64'd1);
        checkOutput("wl_mem_we", 64'(d1_mem_we), 64'd1);
        checkOutput("wl_mem_write_addr", 64'(d1_mem_write_addr), 64'd7);
        checkOutput("wl_mem_wdata", 64'(d1_mem_wdata), 64'hAB);
        applyStimulus(1'b0, 20'd0, 32'h0, 1'b0, 20'd0, 1'b1, 1'b0, 20'd7, 32'h0, 1'b0, 1'b0);
        checkOutput("wl_readback_gnt", 64'(d1_host_gnt), 64'd1);
        idleCycle();
        checkOutput("wl_readback_rdata", 64'(d1_host_rdata), 64'hAB);
        checkOutput("wl_starved", 64'(d1_host_starved), 64'd0);
        idleCycle();
        idleCycle();

        // Interleaved returns through the three-cycle memory
        applyStimulus(1'b0, 20'd0, 32'h0, 1'b1, 20'd1, 1'b0, 1'b0, 20'd0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 20'd0, 32'h0, 1'b0, 20'd0, 1'b1, 1'b0, 20'd2, 32'h0, 1'b0, 1'b0);
        checkOutput("il_host_gnt", 64'(d3_host_gnt), 64'd1);
        applyStimulus(1'b0, 20'd0, 32'h0, 1'b1, 20'd7, 1'b0, 1'b0, 20'd0, 32'h0, 1'b0, 1'b0);
        checkOutput("il_ctrl_not_early", 64'(d3_ctrl_rvalid), 64'd0);
        idleCycle();
        checkOutput("il_r0_ctrl_rvalid", 64'(d3_ctrl_rvalid), 64'd1);
        checkOutput("il_r0_ctrl_rdata", 64'(d3_ctrl_rdata), 64'h1001);
        checkOutput("il_r0_host_rvalid", 64'(d3_host_rvalid), 64'd0);
        idleCycle();
        checkOutput("il_r1_host_rvalid", 64'(d3_host_rvalid), 64'd1);
        checkOutput("il_r1_host_rdata", 64'(d3_host_rdata), 64'h1002);
        checkOutput("il_r1_ctrl_rvalid", 64'(d3_ctrl_rvalid), 64'd0);
        idleCycle();
        checkOutput("il_r2_ctrl_rvalid", 64'(d3_ctrl_rvalid), 64'd1);
        checkOutput("il_r2_ctrl_rdata", 64'(d3_ctrl_rdata), 64'hAB);
        checkOutput("il_r2_host_rvalid", 64'(d3_host_rvalid), 64'd0);
        idleCycle();

        // Reset while a host read is in flight and host_starved is set
        for (int k = 0; k < 9; k++) begin
            applyStimulus(1'b0, 20'd0, 32'h0, 1'b1, 20'd0, 1'b1, 1'b0, 20'd2, 32'h0, 1'b0, 1'b0);
        end
        checkOutput("rm_starved_set", 64'(d1_host_starved), 64'd1);
        applyStimulus(1'b0, 20'd0, 32'h0, 1'b0, 20'd0, 1'b1, 1'b0, 20'd2, 32'h0, 1'b0, 1'b0);
        checkOutput("rm_issue_gnt", 64'(d3_host_gnt), 64'd1);
        idleCycle();
        checkOutput("rm_d1_returned", 64'(d1_host_rvalid), 64'd1);
        arst_in = 1'b1;
        #1;
        checkOutput("rm_d1_rvalid_dropped", 64'(d1_host_rvalid), 64'd0);
        checkOutput("rm_d1_starved_clr", 64'(d1_host_starved), 64'd0);
        checkOutput("rm_d3_starved_clr", 64'(d3_host_starved), 64'd0);
        arst_in = 1'b0;
        idleCycle();
        checkOutput("rm_d3_rvalid_a", 64'(d3_host_rvalid), 64'd0);
        idleCycle();
        checkOutput("rm_d3_rvalid_b", 64'(d3_host_rvalid), 64'd0);
        checkOutput("rm_d3_ctrl_rvalid", 64'(d3_ctrl_rvalid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
